// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter for a single-port word-addressed data memory.
//            Port 0 has priority, port 1 gets a starvation guarantee and a
//            lock mode. Define DMEM_ARB_RR_EN for round-robin conflict
//            resolution instead of the starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DW       = 32,
    parameter int ADDRW    = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             p0_req_i,
    input  logic             p0_we_i,
    input  logic [3:0]       p0_mask_i,
    input  logic [ADDRW-1:0] p0_addr_i,
    input  logic [DW-1:0]    p0_wdata_i,
    output logic             p0_gnt_o,
    output logic             p0_rvalid_o,
    output logic [DW-1:0]    p0_rdata_o,
    input  logic             p1_req_i,
    input  logic             p1_we_i,
    input  logic [3:0]       p1_mask_i,
    input  logic [ADDRW-1:0] p1_addr_i,
    input  logic [DW-1:0]    p1_wdata_i,
    input  logic             p1_lock_i,
    output logic             p1_gnt_o,
    output logic             p1_rvalid_o,
    output logic [DW-1:0]    p1_rdata_o,
    output logic             mem_cs_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_mask_o,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic [DW-1:0]    mem_wdata_o,
    input  logic [DW-1:0]    mem_rdata_i
);

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_LOCK1 = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          p0_rvalid_q, p0_rvalid_d;
    logic          p1_rvalid_q, p1_rvalid_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;
    logic          w_gnt0, w_gnt1;
    logic          w_p1_wins;

`ifdef DMEM_ARB_RR_EN
    // 1 = port 1 was granted last; reset value lets port 0 win the first conflict
    logic last_q, last_d;

    always_comb begin
        w_p1_wins = ~last_q;
        last_d    = last_q;
        if (w_gnt0) begin
            last_d = 1'b0;
        end else if (w_gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        w_p1_wins  = (wait_cnt_q == C_MAX_WAIT);
        wait_cnt_d = wait_cnt_q;
        if (!p1_req_i || w_gnt1) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != C_MAX_WAIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB: begin
                if (w_gnt1 && p1_lock_i) begin
                    state_d = ST_LOCK1;
                end
            end
            ST_LOCK1: begin
                if (!p1_lock_i) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Grant outputs; LOCK1 shuts port 0 out even when port 1 is idle
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (state_q)
            ST_LOCK1: begin
                w_gnt1 = p1_req_i;
            end
            default: begin
                if (p0_req_i && p1_req_i) begin
                    w_gnt1 = w_p1_wins;
                    w_gnt0 = ~w_p1_wins;
                end else begin
                    w_gnt0 = p0_req_i;
                    w_gnt1 = p1_req_i;
                end
            end
        endcase
    end

    always_comb begin
        mem_cs_o    = w_gnt0 | w_gnt1;
        mem_we_o    = 1'b0;
        mem_mask_o  = 4'd0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_gnt1) begin
            mem_we_o    = p1_we_i;
            mem_mask_o  = p1_mask_i;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
        end else if (w_gnt0) begin
            mem_we_o    = p0_we_i;
            mem_mask_o  = p0_mask_i;
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
        end
    end

    always_comb begin
        p0_rvalid_d = w_gnt0 & ~p0_we_i;
        p1_rvalid_d = w_gnt1 & ~p1_we_i;
        p0_rdata_d  = p0_rvalid_d ? mem_rdata_i : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? mem_rdata_i : p1_rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_gnt_o    = w_gnt0;
    assign p1_gnt_o    = w_gnt1;
    assign p0_rvalid_o = p0_rvalid_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed, table-driven bench for dmem_arbiter with a small
//            masked-write memory model behind the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [3:0]  p0_mask, p1_mask;
    logic [7:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_cs, mem_we;
    logic [3:0]  mem_mask;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.DW(32), .ADDRW(8), .MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_mask_i(p0_mask),
        .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_mask_i(p1_mask),
        .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_lock_i(p1_lock),
        .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_mask_o(mem_mask),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: loaded on the first edge, then masked writes
    logic [31:0] mem [256];
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 256; a++) mem[a] <= 32'h0;
            mem[8'h05] <= 32'hDEADBEEF;
            mem[8'h20] <= 32'h11111111;
            mem[8'h21] <= 32'h22222222;
            mem_ready  <= 1'b1;
        end else if (mem_cs && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    assign mem_rdata = mem[mem_addr];

    typedef struct {
        logic        p0_req, p0_we;
        logic [3:0]  p0_mask;
        logic [7:0]  p0_addr;
        logic [31:0] p0_wdata;
        logic        p1_req, p1_we;
        logic [3:0]  p1_mask;
        logic [7:0]  p1_addr;
        logic [31:0] p1_wdata;
        logic        p1_lock;
        logic        g0, g1, cs, we;
        logic [3:0]  mask;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_mask = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_mask = 0; p1_addr = 0; p1_wdata = 0; p1_lock = 0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        p0_req = v.p0_req; p0_we = v.p0_we; p0_mask = v.p0_mask;
        p0_addr = v.p0_addr; p0_wdata = v.p0_wdata;
        p1_req = v.p1_req; p1_we = v.p1_we; p1_mask = v.p1_mask;
        p1_addr = v.p1_addr; p1_wdata = v.p1_wdata; p1_lock = v.p1_lock;
        #2;
        check($sformatf("v%0d gnt0", i), 32'(p0_gnt), 32'(v.g0));
        check($sformatf("v%0d gnt1", i), 32'(p1_gnt), 32'(v.g1));
        check($sformatf("v%0d mem_cs", i), 32'(mem_cs), 32'(v.cs));
        check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v.we));
        check($sformatf("v%0d mem_mask", i), 32'(mem_mask), 32'(v.mask));
        check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(v.addr));
        check($sformatf("v%0d mem_wdata", i), mem_wdata, v.wdata);
        @(posedge clk); #1;
        check($sformatf("v%0d p0_rvalid", i), 32'(p0_rvalid), 32'(v.rv0));
        check($sformatf("v%0d p0_rdata", i), p0_rdata, v.rd0);
        check($sformatf("v%0d p1_rvalid", i), 32'(p1_rvalid), 32'(v.rv1));
        check($sformatf("v%0d p1_rdata", i), p1_rdata, v.rd1);
    endtask

    initial begin
        //           p0: req we mask addr wdata      p1: req we mask addr wdata lock   exp: g0 g1 cs we mask addr wdata   rv0 rd0  rv1 rd1
        vecs[0]  = '{0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,0,        0,0,0,0,4'h0,8'h00,32'h0,        0,32'h0,0,32'h0};
        vecs[1]  = '{1,0,4'hF,8'h05,32'h0,        0,0,4'h0,8'h00,32'h0,0,        1,0,1,0,4'hF,8'h05,32'h0,        1,32'hDEADBEEF,0,32'h0};
        vecs[2]  = '{0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,0,        0,0,0,0,4'h0,8'h00,32'h0,        0,32'hDEADBEEF,0,32'h0};
        vecs[3]  = '{1,1,4'hF,8'h30,32'hCAFEF00D, 0,0,4'h0,8'h00,32'h0,0,        1,0,1,1,4'hF,8'h30,32'hCAFEF00D, 0,32'hDEADBEEF,0,32'h0};
        vecs[4]  = '{0,0,4'h0,8'h00,32'h0,        1,0,4'hF,8'h30,32'h0,0,        0,1,1,0,4'hF,8'h30,32'h0,        0,32'hDEADBEEF,1,32'hCAFEF00D};
        // Both request: four port-0 wins, then the starved port 1 is forced through
        for (int k = 5; k <= 8; k++)
            vecs[k] = '{1,0,4'hF,8'h20,32'h0,     1,0,4'hF,8'h21,32'h0,0,        1,0,1,0,4'hF,8'h20,32'h0,        1,32'h11111111,0,32'hCAFEF00D};
        vecs[9]  = '{1,0,4'hF,8'h20,32'h0,        1,0,4'hF,8'h21,32'h0,0,        0,1,1,0,4'hF,8'h21,32'h0,        0,32'h11111111,1,32'h22222222};
        vecs[10] = '{1,0,4'hF,8'h20,32'h0,        1,0,4'hF,8'h21,32'h0,0,        1,0,1,0,4'hF,8'h20,32'h0,        1,32'h11111111,0,32'h22222222};
        vecs[11] = '{0,0,4'h0,8'h00,32'h0,        1,1,4'h3,8'h10,32'h1234ABCD,1, 0,1,1,1,4'h3,8'h10,32'h1234ABCD, 0,32'h11111111,0,32'h22222222};
        vecs[12] = '{1,0,4'hF,8'h05,32'h0,        1,0,4'hF,8'h10,32'h0,0,        0,1,1,0,4'hF,8'h10,32'h0,        0,32'h11111111,1,32'h0000ABCD};
        vecs[13] = '{1,0,4'hF,8'h05,32'h0,        0,0,4'h0,8'h00,32'h0,0,        1,0,1,0,4'hF,8'h05,32'h0,        1,32'hDEADBEEF,0,32'h0000ABCD};
        vecs[14] = '{0,0,4'h0,8'h00,32'h0,        1,0,4'hF,8'h21,32'h0,1,        0,1,1,0,4'hF,8'h21,32'h0,        0,32'hDEADBEEF,1,32'h22222222};
        // Lock held with no port-1 request: port 0 stalls
        vecs[15] = '{1,0,4'hF,8'h20,32'h0,        0,0,4'h0,8'h00,32'h0,1,        0,0,0,0,4'h0,8'h00,32'h0,        0,32'hDEADBEEF,0,32'h22222222};
        vecs[16] = vecs[15];
        vecs[17] = '{1,0,4'hF,8'h20,32'h0,        0,0,4'h0,8'h00,32'h0,0,        0,0,0,0,4'h0,8'h00,32'h0,        0,32'hDEADBEEF,0,32'h22222222};
        vecs[18] = '{1,0,4'hF,8'h20,32'h0,        0,0,4'h0,8'h00,32'h0,0,        1,0,1,0,4'hF,8'h20,32'h0,        1,32'h11111111,0,32'h22222222};
        vecs[19] = '{0,0,4'h0,8'h00,32'h0,        0,0,4'h0,8'h00,32'h0,0,        0,0,0,0,4'h0,8'h00,32'h0,        0,32'h11111111,0,32'h22222222};

        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset p0_rvalid", 32'(p0_rvalid), 32'h0);
        check("reset p1_rvalid", 32'(p1_rvalid), 32'h0);
        check("reset p0_rdata", p0_rdata, 32'h0);
        check("reset p1_rdata", p1_rdata, 32'h0);
        check("reset mem_cs", 32'(mem_cs), 32'h0);
        check("reset gnt", {30'h0, p1_gnt, p0_gnt}, 32'h0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

`ifndef DMEM_ARB_RR_EN
        for (int i = 0; i < NV; i++) run_vec(i);
`endif

        // Reset mid-LOCK1 while a read response is in flight
        idle_inputs();
        p1_req = 1; p1_mask = 4'hF; p1_addr = 8'h05; p1_lock = 1;
        #2;
        check("lock read gnt1", 32'(p1_gnt), 32'h1);
        @(posedge clk); #1;
        check("lock read rvalid", 32'(p1_rvalid), 32'h1);
        check("lock read rdata", p1_rdata, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        check("async rst p1_rvalid", 32'(p1_rvalid), 32'h0);
        check("async rst p1_rdata", p1_rdata, 32'h0);
        check("async rst p0_rdata", p0_rdata, 32'h0);
        idle_inputs();
        @(posedge clk); #1;
        check("rst held p1_rvalid", 32'(p1_rvalid), 32'h0);
        #2 rst = 1'b0;
        p0_req = 1; p0_mask = 4'hF; p0_addr = 8'h05;
        #1;
        check("post-rst gnt0", 32'(p0_gnt), 32'h1);
        check("post-rst gnt1", 32'(p1_gnt), 32'h0);
        @(posedge clk); #1;
        check("post-rst p0_rvalid", 32'(p0_rvalid), 32'h1);
        check("post-rst p0_rdata", p0_rdata, 32'hDEADBEEF);
        idle_inputs();
        @(posedge clk); #1;
        check("p0_rvalid single pulse", 32'(p0_rvalid), 32'h0);

        // Quiet bus for ten cycles
        for (int c = 0; c < 10; c++) begin
            #2;
            check($sformatf("idle%0d mem", c), {25'h0, mem_cs, mem_we, mem_mask, p0_gnt}, 32'h0);
            check($sformatf("idle%0d gnt1", c), 32'(p1_gnt), 32'h0);
            @(posedge clk); #1;
        end

`ifdef DMEM_ARB_RR_EN
        // Round-robin from reset: p0 first, then strict alternation
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        p0_req = 1; p0_mask = 4'hF; p0_addr = 8'h20;
        p1_req = 1; p1_mask = 4'hF; p1_addr = 8'h21;
        for (int r = 0; r < 4; r++) begin
            #1;
            check($sformatf("rr%0d gnt0", r), 32'(p0_gnt), 32'((r % 2) == 0));
            check($sformatf("rr%0d gnt1", r), 32'(p1_gnt), 32'((r % 2) == 1));
            @(posedge clk); #1;
        end
        idle_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port, word-addressed data memory between the core load/store path (port 0) and a secondary master such as a loader or debug port (port 1).
- Drives the memory's we/cs/mask/addr/wdata inputs and accepts its combinational read data.
- Returns read data to the winning requester through a registered response one cycle after grant.
- Port 0 has priority by default; a starvation counter guarantees port 1 progress, and a lock FSM gives port 1 atomic back-to-back accesses.

Parameters:
- DW, 32, data width; must equal the memory data width.
- ADDRW, 8, word-address width; 8 for 1 KB.
- MAX_WAIT, 4, number of consecutive cycles port 1 may be denied before it is forced to win; range 1..255.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- p0_req_i  in  1  port 0 access request
- p0_we_i  in  1  port 0 write enable (0 = read)
- p0_mask_i  in  4  port 0 byte-lane mask
- p0_addr_i  in  ADDRW  port 0 word address
- p0_wdata_i  in  DW  port 0 write data
- p0_gnt_o  out  1  port 0 granted this cycle (combinational)
- p0_rvalid_o  out  1  port 0 read data valid (registered pulse)
- p0_rdata_o  out  DW  port 0 read data (registered)
- p1_req_i, p1_we_i, p1_mask_i, p1_addr_i, p1_wdata_i  in  same widths as port 0  port 1 request fields
- p1_lock_i  in  1  port 1 requests exclusive ownership across consecutive accesses
- p1_gnt_o  out  1  port 1 granted this cycle (combinational)
- p1_rvalid_o  out  1  port 1 read data valid
- p1_rdata_o  out  DW  port 1 read data
- mem_cs_o  out  1  memory chip select
- mem_we_o  out  1  memory write enable
- mem_mask_o  out  4  memory byte mask
- mem_addr_o  out  ADDRW  memory word address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory combinational read data

Behaviour:
- Reset: state=ARB, wait_cnt=0, both rvalid=0, both rdata=0. Grants and mem_* are combinational and are 0 while no request is pending.
- Handshake:
  - A requester holds req and all fields stable until it sees gnt high on a rising edge.
  - Exactly one access completes per granted cycle.
  - The two gnt outputs are never high together.
- Mem drive:
  - mem_cs_o equals the OR of the two grants.
  - mem_we_o, mem_mask_o, mem_addr_o and mem_wdata_o are muxed from the granted port.
  - All mem_* are 0 when neither port is granted.
- Read latency:
  - On the edge that ends a granted read, mem_rdata_i is captured into that port's rdata register.
  - That port's rvalid goes high for exactly 1 cycle.
  - Writes never assert rvalid.
  - rdata holds its value until the port's next read completes.
- FSM, states ARB and LOCK1:
  - ARB, only one port requesting: that port wins.
  - ARB, both requesting: port 0 wins unless wait_cnt==MAX_WAIT, in which case port 1 wins.
  - ARB to LOCK1: port 1 granted with p1_lock_i=1.
  - LOCK1: port 0 is never granted; port 1 is granted whenever p1_req_i=1.
  - LOCK1 to ARB: on any cycle with p1_lock_i=0. That cycle still grants port 1 if it is requesting.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, when p1_req_i=1 and port 1 is not granted.
  - Clears to 0 when port 1 is granted or p1_req_i=0.
- Boundary cases:
  - Same-address read by one port and pending write by the other: the access that completes first is the one observed. A read granted after a write returns the written data.
  - Reset asserted mid-LOCK1 or mid-response: everything returns to reset values immediately and asynchronously, and no rvalid pulse is emitted.
  - p1_lock_i=1 with p1_req_i=0: stay in LOCK1. Port 0 stalls by design.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined:
  - wait_cnt is removed.
  - When both ports request in ARB, the winner is the port not granted last. A last-grant flop resets to port 1, so port 0 wins the first conflict.
  - LOCK1 behaviour is unchanged.
  - MAX_WAIT is ignored.
- Undefined: fixed priority with starvation counter, as described above.

Test Plan:
- Port 0 only, read addr 0x05 where mem holds 0xDEADBEEF: p0_gnt_o=1 in the request cycle; next cycle p0_rvalid_o=1 and p0_rdata_o=0xDEADBEEF; pulse lasts 1 cycle.
- Both ports request continuously, MAX_WAIT=4: port 0 granted cycles 0-3, port 1 granted cycle 4, wait_cnt back to 0, port 0 granted cycle 5.
- Port 1 write with lock, mask 4'b0011, data 0x1234ABCD to addr 0x10, then read addr 0x10 with lock=0 while p0_req_i=1: p0 denied both cycles; mem_mask_o=0011; read returns 0x0000ABCD when mem started at 0; then state ARB and p0 granted.
- Reset pulse asserted during LOCK1 with a read in flight: rvalid=0 and rdata=0 immediately; after release, p0 alone is granted on its first request.
- No requests: mem_cs_o=0, mem_we_o=0, mem_mask_o=0, both gnt=0 for 10 cycles.
- DMEM_ARB_RR_EN defined, both requesting continuously: grants alternate p0, p1, p0, p1 starting with p0.
